// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared definitions for the UART control blocks.
//   arb_state_t     - 2-bit FSM encoding of the TX arbiter
//   UART_BYTE_W     - width of one UART character
//   TIMEOUT_CYC_DEF - default watchdog limit, used only when UART_ARB_TIMEOUT_EN is defined
package uart_ctrl_pkg;

    localparam int UART_BYTE_W     = 8;
    localparam int TIMEOUT_CYC_DEF = 65535;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Finds the first set bit of req, searching upward from ptr and wrapping at N-1.
// Ports:
//   req  in  N    request vector
//   ptr  in  IDW  highest-priority index
//   idx  out IDW  winning index (0 when any=0)
//   any  out 1    at least one request is set
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int j;

    // Walk from the farthest candidate back to ptr so the last hit,
    // i.e. the closest one to ptr, is the one that sticks.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                any = 1'b1;
                idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_core transmitter between N_REQ byte producers
// with round-robin arbitration. Each transfer is: decide (IDLE), pulse tx_req
// (ISSUE), wait for tx_busy to rise (WAIT_BUSY), then to fall (WAIT_DONE).
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   enable       0 blocks new grants; an in-flight frame still completes
//   req_valid    per-requester byte available (held until req_ready)
//   req_data     byte of requester i at [8*i +: 8]
//   req_ready    one-cycle accept pulse per requester
//   tx_req       one-cycle start pulse to uart_core
//   tx_data      byte to uart_core, held until the next issue
//   tx_busy      uart_core busy
//   grant_valid  transfer in flight
//   grant_id     requester currently or last served
//   arb_err      sticky watchdog timeout
// Optional: define UART_ARB_TIMEOUT_EN to add a 16-bit watchdog on the wait
// states; without it arb_err is tied low and the FSM waits indefinitely.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int IDW         = $clog2(N_REQ),
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_req,
    output logic [UART_BYTE_W-1:0]       tx_data,
    input  logic                         tx_busy,
    output logic                         grant_valid,
    output logic [IDW-1:0]               grant_id,
    output logic                         arb_err
);

    arb_state_t             state, state_next;
    logic [IDW-1:0]         rr_ptr, win, ptr_next;
    logic                   any, start, done, waiting, wd_hit;
    logic [UART_BYTE_W-1:0] win_data;

    rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (win),
        .any (any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win == IDW'(i)) win_data = req_data[UART_BYTE_W*i +: UART_BYTE_W];
    end

    // A busy core (foreign or leftover frame) blocks the decision.
    assign start    = (state == ARB_IDLE) && enable && any && !tx_busy;
    assign waiting  = (state == ARB_WAIT_BUSY) || (state == ARB_WAIT_DONE);
    assign ptr_next = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            ARB_IDLE:      if (start) state_next = ARB_ISSUE;
            ARB_ISSUE:     state_next = ARB_WAIT_BUSY;
            ARB_WAIT_BUSY: begin
                if (wd_hit) begin
                    state_next = ARB_IDLE;
                    done       = 1'b1;
                end else if (tx_busy) begin
                    state_next = ARB_WAIT_DONE;
                end
            end
            ARB_WAIT_DONE: begin
                if (wd_hit || !tx_busy) begin
                    state_next = ARB_IDLE;
                    done       = 1'b1;
                end
            end
            default:       state_next = ARB_IDLE;
        endcase
    end

    // Pointer only moves on completion, so a lone requester is served back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            tx_data  <= '0;
            grant_id <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                tx_data  <= win_data;
                grant_id <= win;
            end
            if (done) rr_ptr <= ptr_next;
        end
    end

    assign tx_req      = (state == ARB_ISSUE);
    assign grant_valid = (state != ARB_IDLE);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++)
            req_ready[i] = (state == ARB_ISSUE) && (grant_id == IDW'(i));
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] wd;

    // Counts cycles spent in the current wait state; any state change restarts it.
    assign wd_hit = waiting && (wd == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state_next != state) wd <= '0;
        else if (waiting)               wd <= wd + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)         arb_err <= 1'b0;
        else if (wd_hit) arb_err <= 1'b1;
    end
`else
    logic unused_waiting;
    assign unused_waiting = waiting;
    assign wd_hit         = 1'b0;
    assign arb_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        arb_err;

    int checks = 0;
    int failures = 0;
    int tx_cnt = 0;

    typedef struct { logic [1:0] id; logic [7:0] b; } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]      valid;
        logic [31:0]     data;
        int              n;
        logic [3:0][1:0] ids;
    } vec_t;
    vec_t tbl[6];

    // Behavioural stand-in for uart_core busy: rises one cycle after tx_req,
    // stays high for a fixed frame length.
    logic [4:0] mcnt;
    logic       model_off = 1'b0;
    logic       busy_force = 1'b0;
    assign tx_busy = busy_force | (mcnt != 5'd0);

    always @(posedge clk) begin
        if (rst)                         mcnt <= '0;
        else if (tx_req && !model_off)   mcnt <= 5'd12;
        else if (mcnt != 5'd0)           mcnt <= mcnt - 5'd1;
    end

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .arb_err     (arb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor; also models producers dropping valid once accepted.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (tx_req === 1'b1) begin
                tx_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_tx_req", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tx_data", {24'd0, tx_data}, {24'd0, e.b});
                    chk("grant_id", {30'd0, grant_id}, {30'd0, e.id});
                    chk("req_ready", {28'd0, req_ready}, 32'd1 << e.id);
                    chk("grant_valid_issue", {31'd0, grant_valid}, 32'd1);
                end
                for (int i = 0; i < 4; i++)
                    if (req_ready[i]) req_valid[i] = 1'b0;
            end else if (req_ready !== 4'd0) begin
                chk("ready_without_tx_req", {28'd0, req_ready}, 32'd0);
            end
        end
    end

    task automatic push(input int id);
        exp_t e;
        e.id = id[1:0];
        e.b  = req_data[8*id +: 8];
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (!(req_valid == 4'd0 && !grant_valid && !tx_busy && sb.size() == 0) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk(name, {31'd0, c < 2000}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_in_done(input string name);
        int c = 0;
        while (!(grant_valid && tx_busy) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk(name, {31'd0, c < 100}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        tbl[0] = '{valid: 4'b0001, data: 32'h0000_00A5, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[1] = '{valid: 4'b1000, data: 32'h5A00_0000, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[2] = '{valid: 4'b1111, data: 32'h1312_1110, n: 4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[3] = '{valid: 4'b1001, data: 32'hC300_0081, n: 2, ids: {2'd0, 2'd0, 2'd3, 2'd0}};
        tbl[4] = '{valid: 4'b0110, data: 32'h0022_4400, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
        tbl[5] = '{valid: 4'b1011, data: 32'hF000_0E0D, n: 3, ids: {2'd0, 2'd1, 2'd0, 2'd3}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_arb_err", {31'd0, arb_err}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            req_data = tbl[v].data;
            for (int k = 0; k < tbl[v].n; k++) push(int'(tbl[v].ids[k]));
            req_valid = tbl[v].valid;
            @(negedge clk);
            chk("issue_latency", {31'd0, tx_req}, 32'd1);
            wait_drain("vec_drain");
        end

        // tx_busy held high in IDLE blocks the grant.
        busy_force = 1'b1;
        repeat (2) @(negedge clk);
        req_data = 32'h0000_7700;
        push(1);
        req_valid = 4'b0010;
        n = tx_cnt;
        repeat (10) @(negedge clk);
        chk("busy_gate_no_tx", tx_cnt, n);
        chk("busy_gate_valid_held", {28'd0, req_valid}, 32'b0010);
        busy_force = 1'b0;
        @(negedge clk);
        chk("busy_release_issue", {31'd0, tx_req}, 32'd1);
        wait_drain("busy_drain");

        // enable dropped while a frame is in flight.
        req_data = 32'h00BB_00AA;
        push(0);
        req_valid = 4'b0001;
        wait_in_done("enable_reach_wait");
        enable = 1'b0;
        req_valid[2] = 1'b1;
        n = 0;
        while (grant_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("enable_frame_done", {31'd0, grant_valid}, 32'd0);
        n = tx_cnt;
        repeat (30) @(negedge clk);
        chk("enable_no_new_tx", tx_cnt, n);
        push(2);
        enable = 1'b1;
        wait_drain("enable_drain");

        // Reset while waiting for the frame to end; rr_ptr must restart at 0.
        req_data = 32'h0000_6600;
        push(1);
        req_valid = 4'b0010;
        wait_in_done("reset_reach_wait");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx_req", {31'd0, tx_req}, 32'd0);
        chk("midrst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("midrst_grant_valid", {31'd0, grant_valid}, 32'd0);
        chk("midrst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("midrst_arb_err", {31'd0, arb_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_sb_empty", sb.size(), 32'd0);
        req_data = 32'h9900_8800;
        push(1);
        push(3);
        req_valid = 4'b1010;
        wait_drain("post_rst_drain");

`ifdef UART_ARB_TIMEOUT_EN
        model_off = 1'b1;
        req_data = 32'h0000_0042;
        push(0);
        req_valid = 4'b0001;
        repeat (30) @(negedge clk);
        chk("timeout_arb_err", {31'd0, arb_err}, 32'd1);
        chk("timeout_idle", {31'd0, grant_valid}, 32'd0);
        model_off = 1'b0;
`else
        chk("arb_err_tied_low", {31'd0, arb_err}, 32'd0);
`endif

        chk("final_sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
